// File: rtl/elevator_pkg.sv
// Shared constants for the elevator floor-request logic.
//   FLOOR_W      width of a floor code
//   FLOORS       number of served floors (codes 1..FLOORS, 0 = empty)
//   QDEPTH       number of request-queue slots
//   FLOOR_NONE   code for an empty slot
//   FLOOR_1..4   floor codes
package elevator_pkg;

    localparam int FLOOR_W = 3;
    localparam int FLOORS  = 4;
    localparam int QDEPTH  = 4;

    localparam logic [FLOOR_W-1:0] FLOOR_NONE = 3'd0;
    localparam logic [FLOOR_W-1:0] FLOOR_1    = 3'd1;
    localparam logic [FLOOR_W-1:0] FLOOR_2    = 3'd2;
    localparam logic [FLOOR_W-1:0] FLOOR_3    = 3'd3;
    localparam logic [FLOOR_W-1:0] FLOOR_4    = 3'd4;

endpackage

// File: rtl/floor_prio_encoder.sv
// Lowest-index priority encoder for pending floor requests.
// Ports:
//   pending     in   pending request vector, bit i = floor i+1
//   floor_code  out  floor code of the lowest set bit, FLOOR_NONE if none
//   valid       out  at least one bit of pending is set
module floor_prio_encoder (
    input  logic [elevator_pkg::FLOORS-1:0]  pending,
    output logic [elevator_pkg::FLOOR_W-1:0] floor_code,
    output logic                             valid
);
    import elevator_pkg::*;

    always_comb begin
        floor_code = FLOOR_NONE;
        valid      = 1'b1;
        if (pending[0])      floor_code = FLOOR_1;
        else if (pending[1]) floor_code = FLOOR_2;
        else if (pending[2]) floor_code = FLOOR_3;
        else if (pending[3]) floor_code = FLOOR_4;
        else                 valid      = 1'b0;
    end

endmodule

// File: rtl/floor_request_queue.sv
// Elevator floor-request FIFO with deduplication.
// Call pulses are latched into a pending vector; one pending request (lowest
// floor first) is serviced per cycle and either appended to the queue or
// discarded (duplicate / current floor / queue full). pop retires the head.
// Ports:
//   clock          system clock, rising edge
//   reset          synchronous active-low reset
//   call_pulse     one-cycle call pulses, bit i = floor i+1
//   current_floor  floor the car is at (values outside 1..4 match nothing)
//   pop            retire the head entry
//   head_floor     slot 0 code, 0 when empty
//   queue_packed   slot k at bits [3k+2:3k]
//   count          number of valid entries
//   empty, full    count==0, count==DEPTH
//   dropped        sticky: a request was discarded because the queue was full
module floor_request_queue #(
    parameter int DEPTH  = 4,
    parameter int FLOORS = 4
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [FLOORS-1:0]                      call_pulse,
    input  logic [elevator_pkg::FLOOR_W-1:0]       current_floor,
    input  logic                                   pop,
    output logic [elevator_pkg::FLOOR_W-1:0]       head_floor,
    output logic [DEPTH*elevator_pkg::FLOOR_W-1:0] queue_packed,
    output logic [2:0]                             count,
    output logic                                   empty,
    output logic                                   full,
    output logic                                   dropped
);
    import elevator_pkg::*;

    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    logic [FLOOR_W-1:0] slot      [DEPTH];
    logic [FLOOR_W-1:0] slot_next [DEPTH];
    logic [FLOOR_W-1:0] shifted   [DEPTH];
    logic [FLOORS-1:0]  pending, pending_next, clear_mask;
    logic [2:0]         count_r, count_next, post_count;
    logic               empty_r, full_r, dropped_r, dropped_next;
    logic [FLOOR_W-1:0] svc_floor;
    logic               svc_valid, pop_ok, dup, accept, drop;

    floor_prio_encoder u_enc (
        .pending    (pending),
        .floor_code (svc_floor),
        .valid      (svc_valid)
    );

    always_comb begin
        pop_ok = pop && (count_r != 3'd0);

        // Pop is applied first so dedup and placement see the post-pop queue.
        for (int k = 0; k < DEPTH - 1; k++) begin
            shifted[k] = pop_ok ? slot[k+1] : slot[k];
        end
        shifted[DEPTH-1] = pop_ok ? FLOOR_NONE : slot[DEPTH-1];
        post_count = count_r - {2'b00, pop_ok};

        // An out-of-range current_floor can never equal a serviced code (1..4).
        dup = (svc_floor == current_floor);
        for (int k = 0; k < DEPTH; k++) begin
            if ((3'(k) < post_count) && (shifted[k] == svc_floor)) dup = 1'b1;
        end

        accept = svc_valid && !dup && (post_count != DEPTH_C);
        drop   = svc_valid && !dup && (post_count == DEPTH_C);

        for (int k = 0; k < DEPTH; k++) begin
            slot_next[k] = shifted[k];
        end
        if (accept) slot_next[post_count[1:0]] = svc_floor;
        count_next = post_count + {2'b00, accept};

        // The serviced bit retires whether accepted or discarded; a fresh
        // pulse on the same edge re-arms it.
        clear_mask = '0;
        for (int i = 0; i < FLOORS; i++) begin
            if (svc_valid && (svc_floor == FLOOR_W'(i + 1))) clear_mask[i] = 1'b1;
        end
        pending_next = (pending & ~clear_mask) | call_pulse;

        dropped_next = pop_ok ? 1'b0 : (dropped_r | drop);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) slot[k] <= FLOOR_NONE;
            pending   <= '0;
            count_r   <= 3'd0;
            empty_r   <= 1'b1;
            full_r    <= 1'b0;
            dropped_r <= 1'b0;
        end else begin
            for (int k = 0; k < DEPTH; k++) slot[k] <= slot_next[k];
            pending   <= pending_next;
            count_r   <= count_next;
            empty_r   <= (count_next == 3'd0);
            full_r    <= (count_next == DEPTH_C);
            dropped_r <= dropped_next;
        end
    end

    always_comb begin
        queue_packed = '0;
        for (int k = 0; k < DEPTH; k++) begin
            queue_packed[FLOOR_W*k +: FLOOR_W] = slot[k];
        end
    end

    assign head_floor = slot[0];
    assign count      = count_r;
    assign empty      = empty_r;
    assign full       = full_r;
    assign dropped    = dropped_r;

endmodule

// File: tb/tb_floor_request_queue.sv
module tb_floor_request_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  call_pulse;
    logic [2:0]  current_floor;
    logic        pop;
    logic [2:0]  head_floor;
    logic [11:0] queue_packed;
    logic [2:0]  count;
    logic        empty, full, dropped;

    always #5 clock = ~clock;

    floor_request_queue dut (
        .clock         (clock),
        .reset         (reset),
        .call_pulse    (call_pulse),
        .current_floor (current_floor),
        .pop           (pop),
        .head_floor    (head_floor),
        .queue_packed  (queue_packed),
        .count         (count),
        .empty         (empty),
        .full          (full),
        .dropped       (dropped)
    );

    typedef struct {
        logic        rst_n;
        logic [3:0]  call;
        logic [2:0]  cur;
        logic        pop;
        logic [11:0] qp;
        logic [2:0]  cnt;
        logic        drp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic [3:0] c, input logic [2:0] cur,
                       input logic p, input logic [11:0] qp, input logic [2:0] cnt,
                       input logic drp);
        vec_t v;
        v.rst_n = r; v.call = c; v.cur = cur; v.pop = p;
        v.qp = qp; v.cnt = cnt; v.drp = drp;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [11:0] qp,
                             input logic [2:0] cnt, input logic drp);
        logic [2:0] h;
        h = qp[2:0];
        chk({tag, " head"},    int'(head_floor),   int'(h));
        chk({tag, " packed"},  int'(queue_packed), int'(qp));
        chk({tag, " count"},   int'(count),        int'(cnt));
        chk({tag, " empty"},   int'(empty),        int'(cnt == 3'd0));
        chk({tag, " full"},    int'(full),         int'(cnt == 3'd4));
        chk({tag, " dropped"}, int'(dropped),      int'(drp));
    endtask

    task automatic step(input logic r, input logic [3:0] c, input logic [2:0] cur,
                        input logic p);
        reset = r; call_pulse = c; current_floor = cur; pop = p;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; call_pulse = 4'b0; current_floor = 3'd1; pop = 1'b0;

        // reset with activity on the inputs, then basic ordering
        add(0, 4'b1111, 1, 1, 12'h000, 0, 0);
        add(0, 4'b0000, 1, 0, 12'h000, 0, 0);
        add(1, 4'b1000, 1, 0, 12'h000, 0, 0);
        add(1, 4'b0000, 1, 0, 12'h004, 1, 0);
        add(1, 4'b0000, 1, 0, 12'h004, 1, 0);
        add(1, 4'b0010, 1, 0, 12'h004, 1, 0);
        add(1, 4'b0000, 1, 0, 12'h014, 2, 0);
        add(1, 4'b0000, 1, 1, 12'h002, 1, 0);
        add(1, 4'b0000, 1, 1, 12'h000, 0, 0);
        add(1, 4'b0000, 1, 1, 12'h000, 0, 0);   // pop while empty
        // simultaneous calls serviced lowest floor first
        add(1, 4'b1110, 1, 0, 12'h000, 0, 0);
        add(1, 4'b0000, 1, 0, 12'h002, 1, 0);
        add(1, 4'b0000, 1, 0, 12'h01A, 2, 0);
        add(1, 4'b0000, 1, 0, 12'h11A, 3, 0);
        add(1, 4'b0000, 1, 1, 12'h023, 2, 0);
        add(1, 4'b0000, 1, 1, 12'h004, 1, 0);
        add(1, 4'b0000, 1, 1, 12'h000, 0, 0);
        // dedup against slot contents and current floor
        add(1, 4'b0100, 2, 0, 12'h000, 0, 0);
        add(1, 4'b0000, 2, 0, 12'h003, 1, 0);
        add(1, 4'b0110, 2, 0, 12'h003, 1, 0);
        add(1, 4'b0000, 2, 0, 12'h003, 1, 0);
        add(1, 4'b0000, 2, 0, 12'h003, 1, 0);
        add(1, 4'b0000, 2, 0, 12'h003, 1, 0);
        add(1, 4'b0000, 2, 1, 12'h000, 0, 0);
        // fill 2,3,4,1 then dup floor 1, floor 2 with pop
        add(1, 4'b0010, 0, 0, 12'h000, 0, 0);
        add(1, 4'b0100, 0, 0, 12'h002, 1, 0);
        add(1, 4'b1000, 0, 0, 12'h01A, 2, 0);
        add(1, 4'b0001, 0, 0, 12'h11A, 3, 0);
        add(1, 4'b0000, 0, 0, 12'h31A, 4, 0);
        add(1, 4'b0011, 0, 0, 12'h31A, 4, 0);
        add(1, 4'b0000, 0, 0, 12'h31A, 4, 0);
        add(1, 4'b0000, 0, 1, 12'h463, 4, 0);
        add(1, 4'b0000, 0, 1, 12'h08C, 3, 0);
        add(1, 4'b0000, 0, 1, 12'h011, 2, 0);
        add(1, 4'b0000, 0, 1, 12'h002, 1, 0);
        add(1, 4'b0000, 0, 1, 12'h000, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].call, vecs[i].cur, vecs[i].pop);
            check_all($sformatf("v%0d", i), vecs[i].qp, vecs[i].cnt, vecs[i].drp);
        end

        // full queue {1,2,3,4}: every further request is a duplicate
        step(1, 4'b1111, 0, 0);
        check_all("fill0", 12'h000, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 4'b0000, 0, 0);
        check_all("full", 12'h8D1, 4, 0);
        step(1, 4'b0100, 0, 0);
        step(1, 4'b0000, 0, 0);
        check_all("full_dup", 12'h8D1, 4, 0);
        step(1, 4'b0000, 0, 1);
        check_all("full_pop", 12'h11A, 3, 0);

        // reset mid-operation with a pending request
        for (int i = 0; i < 3; i++) step(1, 4'b0000, 1, 1);
        check_all("drain", 12'h000, 0, 0);
        step(1, 4'b0010, 1, 0);
        step(1, 4'b1000, 1, 0);
        step(1, 4'b0000, 1, 0);
        check_all("q24", 12'h022, 2, 0);
        step(1, 4'b0100, 1, 0);
        check_all("q24_pend3", 12'h022, 2, 0);
        step(0, 4'b0100, 1, 1);
        check_all("mid_reset", 12'h000, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 4'b0000, 1, 0);
            check_all($sformatf("post_reset%0d", i), 12'h000, 0, 0);
        end

        // pop and enqueue together on a non-full queue
        step(1, 4'b0001, 2, 0);
        step(1, 4'b0000, 2, 0);
        check_all("q1", 12'h001, 1, 0);
        step(1, 4'b0010, 3, 0);
        step(1, 4'b0000, 3, 1);
        check_all("pop_push", 12'h002, 1, 0);

        // current_floor out of range matches nothing
        step(1, 4'b1000, 7, 0);
        step(1, 4'b0000, 7, 0);
        check_all("cur7", 12'h022, 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
